i2s_rx: RTL
===========

Name: i2s_rx

Overview:
- Serial-to-parallel I2S receiver and the downstream counterpart of our I2S transmitter.
- Oversamples BCLK/LRCLK/SDATA in the system clock domain (12 MHz) and reassembles signed left/right PCM words.
- Presents each left/right pair with a one-cycle valid strobe.
- Used for transmitter loopback checking and for external codec/ADC capture.

Parameters:
- WIDTH, 16, bits per captured word (MSB-first).
- DATA_DELAY, 1, BCLK periods between an LRCLK transition and that channel's MSB (1 = Philips I2S, 0 = left-justified).
- SAMPLE_ON_FALL, 1, 1 = sample SDATA on BCLK falling edge; 0 = on rising edge.

Ports:
- clk  input  1  system clock (BCLK must be ≤ clk/4).
- rst  input  1  asynchronous, active-high reset.
- i_bclk  input  1  serial bit clock, asynchronous to clk.
- i_lrclk  input  1  word select; 0 = left, 1 = right.
- i_sdata  input  1  serial data.
- o_left  output  WIDTH  last complete left word (signed).
- o_right  output  WIDTH  last complete right word (signed).
- o_valid  output  1  one-clk pulse; o_left/o_right updated together.
- o_err  output  1  one-clk pulse on a short slot.
- o_locked  output  1  high once a channel boundary has been seen since reset.

Behaviour:
- Reset (async assert; release synchronous to clk):
  - o_left = 0, o_right = 0, o_valid = 0, o_err = 0, o_locked = 0.
  - Synchronizers, shift register, bit counter, left staging register and LR history all cleared.
  - Asserting rst mid-word aborts capture immediately; the partial word is never output.
- Input sync:
  - All three inputs pass through two FF stages, then a third stage on BCLK only, for edge detection.
  - Sample edge = synced BCLK stage2 != stage3, with stage2 == 0 (falling) or == 1 (rising) per SAMPLE_ON_FALL.
  - SDATA and LRCLK are taken from stage2 in the same cycle.
- Effective channel:
  - Per sample edge, a DATA_DELAY-deep shift of sampled LRCLK yields eff_lr.
  - A word boundary is any sample edge where eff_lr differs from its value at the previous sample edge.
- Capture, at each sample edge:
  - At a boundary: shift register <= SDATA as MSB; bit_cnt <= 1; o_locked <= 1.
    - If locked and the previous slot ended with bit_cnt < WIDTH: o_err pulses on the next clk and that partial word is discarded.
  - Otherwise, if bit_cnt < WIDTH: shift SDATA in at the LSB; bit_cnt += 1.
  - Bits beyond WIDTH in a slot are ignored, so 32-bit slots capture their top WIDTH bits.
  - Before the first boundary after reset, nothing is captured.
- Word complete (bit_cnt reaches WIDTH):
  - eff_lr = 0: copy to left staging; set left_ok.
  - eff_lr = 1 and left_ok: o_left <= staging, o_right <= word, o_valid pulses; clear left_ok.
  - eff_lr = 1 without a preceding complete left (start mid-frame or after an error): discarded, no valid.
  - Any o_err clears left_ok.
- Latency: o_valid rises exactly 4 clk cycles after the first clk edge that registers the BCLK transition carrying the final right-channel bit.
  - Constant; the bench checks it.
- o_valid and o_err are never high in the same cycle.
- With the transmitter running at BCLK = clk/4 and 16-bit slots, o_valid pulses exactly once per 128 clk cycles.
- No back-pressure: outputs hold until the next o_valid, and consumers sample on o_valid.

Test Plan:
- Reset: hold rst for 5 clk with BCLK toggling → all outputs 0, o_locked = 0. Release → no o_valid before the first boundary.
- Stereo frame, defaults, BCLK = clk/4, L = 16'h1234, R = 16'hABCD repeated:
  - o_locked rises at the first LRCLK boundary.
  - First o_valid follows the first complete L+R pair with o_left = 16'h1234, o_right = 16'hABCD.
  - Subsequent pulses are spaced 128 clk apart at 4-clk latency.
- Start mid-frame (enable the BCLK model during a right slot): partial words discarded; first o_valid carries the next full L/R pair only.
- Short slot: toggle LRCLK after 10 left bits → one o_err pulse, no o_valid that frame; the next good frame yields a correct o_valid.
- 32-bit slots, WIDTH = 16, L = 32'h7FFF0001, R = 32'h80000002 → o_left = 16'h7FFF, o_right = 16'h8000, no o_err.
- Loopback with transmitter and sine source, plus async rst mid-right-slot:
  - Every o_valid has o_left == o_right == the transmitted sample.
  - After rst, outputs clear at once; o_locked and o_valid recover within two frames.

Source files
------------

// File: rtl/i2s_rx.sv
// i2s_rx: oversampling I2S receiver; reassembles MSB-first left/right words
// from BCLK/LRCLK/SDATA and presents each complete pair with a valid strobe.
module i2s_rx #(
    parameter int WIDTH          = 16,
    parameter int DATA_DELAY     = 1,
    parameter bit SAMPLE_ON_FALL = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_bclk,
    input  logic             i_lrclk,
    input  logic             i_sdata,
    output logic [WIDTH-1:0] o_left,
    output logic [WIDTH-1:0] o_right,
    output logic             o_valid,
    output logic             o_err,
    output logic             o_locked
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] WMAX = CW'(WIDTH);

    logic [1:0]            rs;
    logic                  ir;
    logic [2:0]            bs;
    logic [1:0]            ls, ds;
    logic [1:0]            p_e, p_d, p_l;
    logic [DATA_DELAY:0]   lr_h;
    logic [DATA_DELAY+1:0] lr_n;
    logic [WIDTH-2:0]      sr;
    logic [WIDTH-1:0]      stage, word;
    logic [CW-1:0]         cnt, cnt_n;
    logic                  left_ok, edge_s, eff, bnd, cap, done;

    // assert immediately, release two clocks later in the clk domain
    always_ff @(posedge clk or posedge rst) begin
        if (rst) rs <= 2'b11;
        else     rs <= {rs[0], 1'b0};
    end
    assign ir = rs[1];

    always_comb begin
        edge_s = (bs[1] != bs[2]) && (bs[1] != SAMPLE_ON_FALL);
        lr_n   = {lr_h, p_l[1]};
        eff    = lr_n[DATA_DELAY];
        bnd    = p_e[1] && (eff != lr_n[DATA_DELAY+1]);
        cap    = bnd || (p_e[1] && o_locked && cnt < WMAX);
        word   = bnd ? {{(WIDTH-1){1'b0}}, p_d[1]} : {sr, p_d[1]};
        cnt_n  = bnd ? CW'(1) : cnt + CW'(1);
        done   = cap && cnt_n == WMAX;
    end

    // the two-deep p_* pipeline fixes the edge-to-valid latency at 4 clocks
    always_ff @(posedge clk or posedge ir) begin
        if (ir) begin
            bs       <= '0;
            ls       <= '0;
            ds       <= '0;
            p_e      <= '0;
            p_d      <= '0;
            p_l      <= '0;
            lr_h     <= '0;
            sr       <= '0;
            cnt      <= '0;
            stage    <= '0;
            left_ok  <= 1'b0;
            o_left   <= '0;
            o_right  <= '0;
            o_valid  <= 1'b0;
            o_err    <= 1'b0;
            o_locked <= 1'b0;
        end else begin
            bs      <= {bs[1:0], i_bclk};
            ls      <= {ls[0], i_lrclk};
            ds      <= {ds[0], i_sdata};
            p_e     <= {p_e[0], edge_s};
            p_d     <= {p_d[0], ds[1]};
            p_l     <= {p_l[0], ls[1]};
            o_valid <= 1'b0;
            o_err   <= 1'b0;
            if (p_e[1]) lr_h <= lr_n[DATA_DELAY:0];
            if (cap) begin
                sr  <= word[WIDTH-2:0];
                cnt <= cnt_n;
            end
            if (bnd) o_locked <= 1'b1;
            if (bnd && o_locked && cnt < WMAX) begin
                o_err   <= 1'b1;
                left_ok <= 1'b0;
            end else if (done && !eff) begin
                stage   <= word;
                left_ok <= 1'b1;
            end else if (done && left_ok) begin
                o_left  <= stage;
                o_right <= word;
                o_valid <= 1'b1;
                left_ok <= 1'b0;
            end
        end
    end
endmodule
